regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised 2-read / 2-write register file with per-register pending (scoreboard) bits and optional write-to-read bypass. It is the next-generation register file for the pipelined core: it serves decode-stage operand reads and accepts two writeback streams, ALU (port 0) and load/long-latency (port 1). The scoreboard lets issue logic stall on registers whose producer has not yet written back.

## Interface
Parameters:
- WIDTH, 32, data word width in bits
- AW, 5, address width; depth = 2**AW entries; entry 0 reads as zero

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- ra0  in  AW  read address, port 0
- rd0  out  WIDTH  read data, port 0
- rdy0  out  1  entry ra0 not pending
- ra1  in  AW  read address, port 1
- rd1  out  WIDTH  read data, port 1
- rdy1  out  1  entry ra1 not pending
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  WIDTH  write data, port 0
- we1  in  1  write enable, port 1
- wa1  in  AW  write address, port 1
- wd1  in  WIDTH  write data, port 1
- res_en  in  1  reserve request: mark res_addr pending
- res_addr  in  AW  entry to reserve
- pend_cnt  out  AW+1  number of entries currently pending

## Operation
- Storage: 2**AW x WIDTH registers plus 2**AW pending bits. Entry 0 is never written and never pending. It always reads 0 with rdy=1.
- Writes take effect on the clock edge when weN=1 and waN!=0.
  - Both ports to the same nonzero address: port 1 data wins.
  - Each write clears the pending bit of its address.
- Reserve takes effect on the clock edge when res_en=1 and res_addr!=0. It sets the pending bit.
  - Reserve and write to the same address in the same cycle: the pending bit ends set (new producer wins). Data is still written.
- Reads are combinational from stored state (see Configuration for bypass).
  - rdyN = ~pending[raN], forced to 1 when raN=0.
- pend_cnt is a registered population count of the pending bits.
  - It is updated on the same edge as the bits, so it always equals the count of set bits after that edge.
  - Range 0..2**AW-1.
- Writes to a non-pending entry are legal and do not alter other pending bits.

## Timing
- Reset (rst=1 at an edge): all entries become 0, all pending bits clear, pend_cnt=0.
  - Afterwards rd0=rd1=0 and rdy0=rdy1=1 for any address.
  - Reset overrides any concurrent write or reserve.
  - Reset asserted mid-operation discards all pending state in one cycle.
- Write latency: without bypass, data is visible on rdN in the cycle after the write edge. With bypass, it is visible in the same cycle (combinational).
- Reserve latency: rdyN drops the cycle after the res_en edge.
- Pending clear: without bypass, rdyN rises the cycle after the writeback edge. With bypass, rdyN=1 in the writeback cycle itself.
- pend_cnt changes only at clock edges. Its net change per edge is in -2..+1.
- There is no handshake. All inputs are sampled every edge. There are no stall or backpressure outputs.

## Configuration
- RF_BYPASS_EN defined:
  - When raN matches an active write address (weN=1, nonzero), rdN returns that write's data. Port 1 takes priority over port 0.
  - rdyN is forced to 1 in that case, unless res_en=1 with res_addr=raN in the same cycle.
- RF_BYPASS_EN undefined: rdN and rdyN reflect registered state only. There are no comb paths from wd/we/wa/res_* to read outputs.

## Test plan
- Reset: hold rst 2 cycles with we0=1, wa0=3, wd0=0xDEAD -> r[3]=0, rd0=0 at ra0=3, rdy0=1, pend_cnt=0.
- Write and r0: write 0x1234 to entry 5 and 0xFFFF to entry 0 -> next cycle rd0(ra0=5)=0x1234, rd1(ra1=0)=0.
- Dual-write collision: we0/we1 both to entry 7, with wd0=0xA, wd1=0xB -> r[7]=0xB.
- Scoreboard:
  - Reserve 9 -> next cycle rdy1(ra1=9)=0, pend_cnt=1.
  - Write 0x55 to 9 via port 1 -> next cycle rdy1=1, rd1=0x55, pend_cnt=0.
- Reserve+write same cycle on entry 4 (previously pending) -> entry 4 stays pending, data updated, pend_cnt unchanged.
- Bypass (RF_BYPASS_EN defined): ra0=6, we0=1, wa0=6, wd0=0x77 -> rd0=0x77 in the same cycle. With the macro undefined, the old value is shown and 0x77 appears one cycle later.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : 2-read / 2-write register file with per-entry pending
//                (scoreboard) bits and a registered pending-entry count.
//                Entry 0 is hard-wired to zero and is never pending.
//                Optional write-to-read bypass is enabled by defining the
//                macro RF_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb #(
    parameter int WIDTH = 32,
    parameter int AW    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra0,
    output logic [WIDTH-1:0] rd0,
    output logic             rdy0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    output logic             rdy1,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    input  logic             res_en,
    input  logic [AW-1:0]    res_addr,
    output logic [AW:0]      pend_cnt
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    // Qualified write / reserve strobes; address 0 is never a target.
    logic wr0_act;
    logic wr1_act;
    logic res_act;

    assign wr0_act = we0 && (wa0 != '0);
    assign wr1_act = we1 && (wa1 != '0);
    assign res_act = res_en && (res_addr != '0);

    // Next pending vector: writebacks clear, then a reserve sets (new producer wins).
    always_comb begin
        pend_d = pend_q;
        if (wr0_act) begin
            pend_d[wa0] = 1'b0;
        end
        if (wr1_act) begin
            pend_d[wa1] = 1'b0;
        end
        if (res_act) begin
            pend_d[res_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Population count of the next pending vector so the count tracks the bits.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + {{AW{1'b0}}, pend_d[i]};
        end
    end

    // Pending bits and pending count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage array; port 1 is written last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0_act) begin
                mem_q[wa0] <= wd0;
            end
            if (wr1_act) begin
                mem_q[wa1] <= wd1;
            end
        end
    end

    assign pend_cnt = cnt_q;

    // Registered-state view of each read port.
    logic [WIDTH-1:0] rd0_st;
    logic [WIDTH-1:0] rd1_st;
    logic             rdy0_st;
    logic             rdy1_st;

    assign rd0_st  = (ra0 == '0) ? '0 : mem_q[ra0];
    assign rd1_st  = (ra1 == '0) ? '0 : mem_q[ra1];
    assign rdy0_st = (ra0 == '0) ? 1'b1 : ~pend_q[ra0];
    assign rdy1_st = (ra1 == '0) ? 1'b1 : ~pend_q[ra1];

`ifdef RF_BYPASS_EN
    // Read port 0 with forwarding from in-flight writes (port 1 has priority).
    always_comb begin
        rd0  = rd0_st;
        rdy0 = rdy0_st;
        if (wr1_act && (wa1 == ra0)) begin
            rd0 = wd1;
        end else if (wr0_act && (wa0 == ra0)) begin
            rd0 = wd0;
        end
        if ((wr1_act && (wa1 == ra0)) || (wr0_act && (wa0 == ra0))) begin
            if (!(res_en && (res_addr == ra0))) begin
                rdy0 = 1'b1;
            end
        end
    end

    // Read port 1 with forwarding from in-flight writes (port 1 has priority).
    always_comb begin
        rd1  = rd1_st;
        rdy1 = rdy1_st;
        if (wr1_act && (wa1 == ra1)) begin
            rd1 = wd1;
        end else if (wr0_act && (wa0 == ra1)) begin
            rd1 = wd0;
        end
        if ((wr1_act && (wa1 == ra1)) || (wr0_act && (wa0 == ra1))) begin
            if (!(res_en && (res_addr == ra1))) begin
                rdy1 = 1'b1;
            end
        end
    end
`else
    // Reads see registered state only; no combinational write-side paths.
    always_comb begin
        rd0  = rd0_st;
        rdy0 = rdy0_st;
        rd1  = rd1_st;
        rdy1 = rdy1_st;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb: directed scenarios plus
//                randomized traffic against an array-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2 ** AW;

    logic             clk;
    logic             rst;
    logic [AW-1:0]    ra0;
    logic [WIDTH-1:0] rd0;
    logic             rdy0;
    logic [AW-1:0]    ra1;
    logic [WIDTH-1:0] rd1;
    logic             rdy1;
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [WIDTH-1:0] wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [WIDTH-1:0] wd1;
    logic             res_en;
    logic [AW-1:0]    res_addr;
    logic [AW:0]      pend_cnt;

    int checks;
    int failures;

    // Reference model: plain contents and pending flags.
    logic [WIDTH-1:0] m_mem  [DEPTH];
    bit               m_pend [DEPTH];

    regfile_sb #(.WIDTH(WIDTH), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .ra0      (ra0),
        .rd0      (rd0),
        .rdy0     (rdy0),
        .ra1      (ra1),
        .rd1      (rd1),
        .rdy1     (rdy1),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .res_en   (res_en),
        .res_addr (res_addr),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += m_pend[i] ? 1 : 0;
        return n;
    endfunction

    // Expected read data for an address given current inputs.
    function automatic logic [WIDTH-1:0] exp_rd(input logic [AW-1:0] a);
        logic [WIDTH-1:0] v;
        v = (a == 0) ? '0 : m_mem[a];
`ifdef RF_BYPASS_EN
        if (a != 0 && we1 && wa1 == a) v = wd1;
        else if (a != 0 && we0 && wa0 == a) v = wd0;
`endif
        return v;
    endfunction

    function automatic logic exp_rdy(input logic [AW-1:0] a);
        logic v;
        v = (a == 0) ? 1'b1 : !m_pend[a];
`ifdef RF_BYPASS_EN
        if (a != 0 && ((we1 && wa1 == a) || (we0 && wa0 == a)) &&
            !(res_en && res_addr == a)) v = 1'b1;
`endif
        return v;
    endfunction

    // Advance one clock edge, applying the architectural rules to the model.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                m_mem[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            if (we0 && wa0 != 0) begin m_mem[wa0] = wd0; m_pend[wa0] = 1'b0; end
            if (we1 && wa1 != 0) begin m_mem[wa1] = wd1; m_pend[wa1] = 1'b0; end
            if (res_en && res_addr != 0) m_pend[res_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 0; we0 = 0; we1 = 0; res_en = 0;
        wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; res_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; we0 = 1; wa0 = 5'd3; wd0 = 32'hDEAD;
        res_en = 1; res_addr = 5'd3;
        step();
        step();
        idle_inputs();
        ra0 = 5'd3; ra1 = 5'd17;
        #1;
        checks++; if (rd0 !== 32'h0) begin failures++; $display("FAIL reset_rd0 got=%h exp=0", rd0); end
        checks++; if (rdy0 !== 1'b1) begin failures++; $display("FAIL reset_rdy0 got=%b exp=1", rdy0); end
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL reset_rdy1 got=%b exp=1", rdy1); end
        checks++; if (pend_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_write_r0();
        idle_inputs();
        we0 = 1; wa0 = 5'd5; wd0 = 32'h1234;
        we1 = 1; wa1 = 5'd0; wd1 = 32'hFFFF;
        step();
        idle_inputs();
        ra0 = 5'd5; ra1 = 5'd0;
        #1;
        checks++; if (rd0 !== 32'h1234) begin failures++; $display("FAIL write_rd0 got=%h exp=1234", rd0); end
        checks++; if (rd1 !== 32'h0) begin failures++; $display("FAIL r0_rd1 got=%h exp=0", rd1); end
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL r0_rdy1 got=%b exp=1", rdy1); end
    endtask

    task automatic test_collision();
        idle_inputs();
        we0 = 1; wa0 = 5'd7; wd0 = 32'hA;
        we1 = 1; wa1 = 5'd7; wd1 = 32'hB;
        step();
        idle_inputs();
        ra0 = 5'd7;
        #1;
        checks++; if (rd0 !== 32'hB) begin failures++; $display("FAIL collision_rd0 got=%h exp=b", rd0); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        res_en = 1; res_addr = 5'd9;
        step();
        idle_inputs();
        ra1 = 5'd9;
        #1;
        checks++; if (rdy1 !== 1'b0) begin failures++; $display("FAIL sb_rdy1_pending got=%b exp=0", rdy1); end
        checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL sb_cnt_one got=%0d exp=1", pend_cnt); end
        we1 = 1; wa1 = 5'd9; wd1 = 32'h55;
        step();
        idle_inputs();
        #1;
        checks++; if (rdy1 !== 1'b1) begin failures++; $display("FAIL sb_rdy1_clear got=%b exp=1", rdy1); end
        checks++; if (rd1 !== 32'h55) begin failures++; $display("FAIL sb_rd1 got=%h exp=55", rd1); end
        checks++; if (pend_cnt !== 6'd0) begin failures++; $display("FAIL sb_cnt_zero got=%0d exp=0", pend_cnt); end
    endtask

    task automatic test_reserve_write();
        idle_inputs();
        res_en = 1; res_addr = 5'd4;
        step();
        res_en = 1; res_addr = 5'd4;
        we0 = 1; wa0 = 5'd4; wd0 = 32'h44;
        step();
        idle_inputs();
        ra0 = 5'd4;
        #1;
        checks++; if (rdy0 !== 1'b0) begin failures++; $display("FAIL rw_rdy0 got=%b exp=0", rdy0); end
        checks++; if (rd0 !== 32'h44) begin failures++; $display("FAIL rw_rd0 got=%h exp=44", rd0); end
        checks++; if (pend_cnt !== 6'd1) begin failures++; $display("FAIL rw_cnt got=%0d exp=1", pend_cnt); end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_same;
        idle_inputs();
        we1 = 1; wa1 = 5'd6; wd1 = 32'h11;
        step();
        idle_inputs();
        ra0 = 5'd6;
        we0 = 1; wa0 = 5'd6; wd0 = 32'h77;
        #1;
`ifdef RF_BYPASS_EN
        exp_same = 32'h77;
`else
        exp_same = 32'h11;
`endif
        checks++; if (rd0 !== exp_same) begin failures++; $display("FAIL bypass_same got=%h exp=%h", rd0, exp_same); end
        step();
        idle_inputs();
        #1;
        checks++; if (rd0 !== 32'h77) begin failures++; $display("FAIL bypass_next got=%h exp=77", rd0); end
    endtask

    task automatic test_random();
        int prev_cnt;
        int diff;
        for (int n = 0; n < 400; n++) begin
            rst      = ($urandom_range(0, 49) == 0);
            we0      = $urandom_range(0, 1);
            we1      = $urandom_range(0, 1);
            res_en   = $urandom_range(0, 1);
            wa0      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            wa1      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            res_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra0      = $urandom_range(0, 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            ra1      = $urandom_range(0, 1) ? wa1 : 5'($urandom);
            wd0      = $urandom;
            wd1      = $urandom;
            #1;
            checks++; if (rd0 !== exp_rd(ra0)) begin failures++; $display("FAIL rnd_rd0 n=%0d a=%0d got=%h exp=%h", n, ra0, rd0, exp_rd(ra0)); end
            checks++; if (rd1 !== exp_rd(ra1)) begin failures++; $display("FAIL rnd_rd1 n=%0d a=%0d got=%h exp=%h", n, ra1, rd1, exp_rd(ra1)); end
            checks++; if (rdy0 !== exp_rdy(ra0)) begin failures++; $display("FAIL rnd_rdy0 n=%0d a=%0d got=%b exp=%b", n, ra0, rdy0, exp_rdy(ra0)); end
            checks++; if (rdy1 !== exp_rdy(ra1)) begin failures++; $display("FAIL rnd_rdy1 n=%0d a=%0d got=%b exp=%b", n, ra1, rdy1, exp_rdy(ra1)); end
            prev_cnt = model_count();
            step();
            checks++; if (int'(pend_cnt) !== model_count()) begin failures++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, pend_cnt, model_count()); end
            diff = model_count() - prev_cnt;
            if (!rst) begin
                checks++; if (diff < -2 || diff > 1) begin failures++; $display("FAIL rnd_cnt_delta n=%0d got=%0d exp=-2..1", n, diff); end
            end
        end
        idle_inputs();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        ra0 = '0;
        ra1 = '0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
        end
        test_reset();
        test_write_r0();
        test_collision();
        test_scoreboard();
        test_reserve_write();
        test_bypass();
        test_random();
        test_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
